load_writeback_unit: RTL and testbench

Sequencer that executes one load instruction. It reads the base register from the register file, forms the effective address, runs a req/ack memory read, extracts and extends the byte, halfword or word, then drives the register file write port. It sits between decode and the register file/data memory and is the initiator on the register file's read and write ports.

---
 rtl/load_writeback_unit.sv | 147 ++++++++++++++
 tb/tb_load_writeback_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/load_writeback_unit.sv
// Load sequencer: reads the base register, forms the effective address, performs a
// req/ack memory read, extracts and extends the loaded value and writes it back.
module load_writeback_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [4:0]  ld_base_reg,
  input  logic [4:0]  ld_dest_reg,
  input  logic [31:0] ld_offset,
  input  logic [2:0]  ld_funct3,
  output logic [4:0]  rf_read_reg,
  input  logic [31:0] rf_read_data,
  output logic        rf_reg_write,
  output logic [4:0]  rf_write_reg,
  output logic [31:0] rf_write_data,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        ld_done,
  output logic        ld_error,
  output logic [1:0]  err_code
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_WB    = 3'd4;
  localparam logic [2:0] S_ERR   = 3'd5;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_FUNCT3   = 2'b11;

  logic [2:0]  state_reg;
  logic [4:0]  base_reg;
  logic [4:0]  dest_reg;
  logic [31:0] offset_reg;
  logic [2:0]  funct3_reg;
  logic [31:0] addr_reg;
  logic [31:0] data_reg;
  logic [7:0]  cnt_reg;
  logic [1:0]  err_reg;

  logic        funct3_ok;
  logic        misaligned;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] extract_next;

  always_comb begin
    funct3_ok = (funct3_reg == 3'b000) || (funct3_reg == 3'b001) || (funct3_reg == 3'b010) ||
                (funct3_reg == 3'b100) || (funct3_reg == 3'b101);
    misaligned = ((funct3_reg[1:0] == 2'b01) && addr_reg[0]) ||
                 ((funct3_reg == 3'b010) && (addr_reg[1:0] != 2'b00));
  end

  // Lane selection uses the byte offset of the effective address within the word.
  always_comb begin
    byte_sel = mem_rdata[{addr_reg[1:0], 3'b000} +: 8];
    half_sel = mem_rdata[{addr_reg[1], 4'b0000} +: 16];
    case (funct3_reg)
      3'b000:  extract_next = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  extract_next = {24'd0, byte_sel};
      3'b001:  extract_next = {{16{half_sel[15]}}, half_sel};
      3'b101:  extract_next = {16'd0, half_sel};
      default: extract_next = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= S_IDLE;
      base_reg   <= '0;
      dest_reg   <= '0;
      offset_reg <= '0;
      funct3_reg <= '0;
      addr_reg   <= '0;
      data_reg   <= '0;
      cnt_reg    <= '0;
      err_reg    <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (ld_valid) begin
            base_reg   <= ld_base_reg;
            dest_reg   <= ld_dest_reg;
            offset_reg <= ld_offset;
            funct3_reg <= ld_funct3;
            state_reg  <= S_FETCH;
          end
        end
        S_FETCH: begin
          addr_reg  <= rf_read_data + offset_reg;
          state_reg <= S_CHECK;
        end
        S_CHECK: begin
          cnt_reg <= '0;
          if (!funct3_ok) begin
            err_reg   <= ERR_FUNCT3;
            state_reg <= S_ERR;
          end else if (misaligned) begin
            err_reg   <= ERR_MISALIGN;
            state_reg <= S_ERR;
          end else begin
            state_reg <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Ack wins over timeout, so an ack in the final allowed cycle succeeds.
          if (mem_ack) begin
            data_reg  <= extract_next;
            state_reg <= S_WB;
          end else if (cnt_reg == CNT_LAST) begin
            err_reg   <= ERR_TIMEOUT;
            state_reg <= S_ERR;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    ld_ready      = (state_reg == S_IDLE) && !reset;
    rf_read_reg   = (state_reg == S_FETCH) ? base_reg : 5'd0;
    mem_req       = (state_reg == S_WAIT);
    mem_addr      = (state_reg == S_WAIT) ? {addr_reg[31:2], 2'b00} : 32'd0;
    ld_done       = (state_reg == S_WB);
    rf_reg_write  = (state_reg == S_WB) && (dest_reg != 5'd0);
    rf_write_reg  = (state_reg == S_WB) ? dest_reg : 5'd0;
    rf_write_data = (state_reg == S_WB) ? data_reg : 32'd0;
    ld_error      = (state_reg == S_ERR);
    err_code      = (state_reg == S_ERR) ? err_reg : 2'b00;
  end

endmodule

// File: tb/tb_load_writeback_unit.sv
// Directed-vector bench for load_writeback_unit with a behavioural register file.
module tb_load_writeback_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_base_reg;
  logic [4:0]  ld_dest_reg;
  logic [31:0] ld_offset;
  logic [2:0]  ld_funct3;
  logic [4:0]  rf_read_reg;
  logic [31:0] rf_read_data;
  logic        rf_reg_write;
  logic [4:0]  rf_write_reg;
  logic [31:0] rf_write_data;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        ld_done;
  logic        ld_error;
  logic [1:0]  err_code;

  logic [31:0] rf_model [32];

  int errors = 0;
  int checks = 0;

  int          o_req, o_done_cyc, o_err_cyc, o_writes, o_overlap;
  logic [31:0] o_addr, o_wdata;
  logic [4:0]  o_wreg, o_rreg;
  logic [1:0]  o_code;
  logic        o_ready, o_hung;

  always #5 clk = ~clk;

  assign rf_read_data = rf_model[rf_read_reg];

  load_writeback_unit #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_base_reg(ld_base_reg), .ld_dest_reg(ld_dest_reg),
    .ld_offset(ld_offset), .ld_funct3(ld_funct3),
    .rf_read_reg(rf_read_reg), .rf_read_data(rf_read_data),
    .rf_reg_write(rf_reg_write), .rf_write_reg(rf_write_reg), .rf_write_data(rf_write_data),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ld_done(ld_done), .ld_error(ld_error), .err_code(err_code)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one load and records what the unit did; ack_at is the 1-based MEM_WAIT cycle to ack in (0 = never).
  task automatic run_load(input logic [4:0] base, input logic [4:0] dest, input logic [31:0] off,
                          input logic [2:0] f3, input int ack_at, input logic [31:0] rdata);
    o_req = 0; o_done_cyc = 0; o_err_cyc = 0; o_writes = 0; o_overlap = 0;
    o_addr = '0; o_wdata = '0; o_wreg = '0; o_code = '0; o_ready = 1'b0; o_hung = 1'b1;
    ld_base_reg = base; ld_dest_reg = dest; ld_offset = off; ld_funct3 = f3; ld_valid = 1'b1;
    tick();
    ld_valid = 1'b0;
    o_rreg = rf_read_reg;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      mem_ack = 1'b0;
      if (mem_req) begin
        o_req++;
        o_addr = mem_addr;
        if (o_req == ack_at) begin
          mem_ack = 1'b1;
          mem_rdata = rdata;
        end
      end
      if (mem_req && rf_reg_write) o_overlap++;
      if (rf_reg_write) begin
        o_writes++;
        o_wreg = rf_write_reg;
        o_wdata = rf_write_data;
      end
      if (ld_done || ld_error) begin
        if (ld_done) o_done_cyc = cyc;
        if (ld_error) begin
          o_err_cyc = cyc;
          o_code = err_code;
        end
        tick();
        o_ready = ld_ready;
        o_hung = 1'b0;
        break;
      end
      tick();
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; ld_valid = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    ld_base_reg = '0; ld_dest_reg = '0; ld_offset = '0; ld_funct3 = '0;
    tick(); tick();
    checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ld_ready); end
    checks++; if ({mem_req, rf_reg_write, ld_done, ld_error, err_code} !== 6'b0) begin
      errors++; $display("FAIL reset_outputs: got %b expected 000000", {mem_req, rf_reg_write, ld_done, ld_error, err_code});
    end
    reset = 1'b0;
    tick();
    checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after: got %b expected 1", ld_ready); end
  endtask

  task automatic test_lw_basic();
    rf_model[5] = 32'h0000_1000;
    run_load(5'd5, 5'd7, 32'd8, 3'b010, 1, 32'hDEAD_BEEF);
    checks++; if (o_hung !== 1'b0) begin errors++; $display("FAIL lw_terminate: hung=%b expected 0", o_hung); end
    checks++; if (o_rreg !== 5'd5) begin errors++; $display("FAIL lw_read_reg: got %0d expected 5", o_rreg); end
    checks++; if (o_addr !== 32'h0000_1008) begin errors++; $display("FAIL lw_addr: got %h expected 00001008", o_addr); end
    checks++; if (o_done_cyc != 4) begin errors++; $display("FAIL lw_done_cycle: got %0d expected 4", o_done_cyc); end
    checks++; if (o_writes != 1 || o_wreg !== 5'd7) begin
      errors++; $display("FAIL lw_write: writes=%0d reg=%0d expected 1 write to reg 7", o_writes, o_wreg);
    end
    checks++; if (o_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_data: got %h expected deadbeef", o_wdata); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL lw_ready_cycle5: got %b expected 1", o_ready); end
    checks++; if (o_overlap != 0) begin errors++; $display("FAIL lw_overlap: got %0d expected 0", o_overlap); end
  endtask

  task automatic test_extract();
    logic [2:0]  f3_tab  [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000};
    logic [31:0] off_tab [6] = '{32'd3, 32'd3, 32'd2, 32'd2, 32'hFFFF_FFFC, 32'd0};
    logic [31:0] exp_tab [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_80FF,
                                 32'h80FF_1234, 32'h0000_0034};
    logic [31:0] adr_tab [6] = '{32'h1000, 32'h1000, 32'h1000, 32'h1000, 32'h0FFC, 32'h1000};
    rf_model[6] = 32'h0000_1000;
    for (int i = 0; i < 6; i++) begin
      run_load(5'd6, 5'd9, off_tab[i], f3_tab[i], 1, 32'h80FF_1234);
      checks++; if (o_wdata !== exp_tab[i] || o_addr !== adr_tab[i]) begin
        errors++; $display("FAIL extract_%0d: data=%h addr=%h expected data=%h addr=%h", i, o_wdata, o_addr, exp_tab[i], adr_tab[i]);
      end
      $display("extract %0d funct3=%b off=%h data=%h", i, f3_tab[i], off_tab[i], o_wdata);
    end
  endtask

  task automatic test_errors();
    logic [2:0]  f3_tab  [4] = '{3'b001, 3'b010, 3'b011, 3'b111};
    logic [31:0] off_tab [4] = '{32'd1, 32'd2, 32'd0, 32'd1};
    logic [1:0]  exp_tab [4] = '{2'b01, 2'b01, 2'b11, 2'b11};
    rf_model[6] = 32'h0000_1000;
    for (int i = 0; i < 4; i++) begin
      run_load(5'd6, 5'd9, off_tab[i], f3_tab[i], 1, 32'h1111_1111);
      checks++; if (o_err_cyc != 3 || o_code !== exp_tab[i]) begin
        errors++; $display("FAIL error_%0d: cycle=%0d code=%b expected cycle 3 code %b", i, o_err_cyc, o_code, exp_tab[i]);
      end
      checks++; if (o_req != 0 || o_writes != 0 || o_done_cyc != 0) begin
        errors++; $display("FAIL error_side_%0d: req=%0d writes=%0d done=%0d expected 0 0 0", i, o_req, o_writes, o_done_cyc);
      end
      $display("error %0d funct3=%b off=%0d code=%b", i, f3_tab[i], off_tab[i], o_code);
    end
  endtask

  task automatic test_timeout();
    rf_model[5] = 32'h0000_1000;
    run_load(5'd5, 5'd3, 32'd4, 3'b010, 0, 32'h0);
    checks++; if (o_req != 16) begin errors++; $display("FAIL timeout_req_cycles: got %0d expected 16", o_req); end
    checks++; if (o_err_cyc != 19 || o_code !== 2'b10) begin
      errors++; $display("FAIL timeout_error: cycle=%0d code=%b expected cycle 19 code 10", o_err_cyc, o_code);
    end
    checks++; if (o_writes != 0) begin errors++; $display("FAIL timeout_write: got %0d expected 0", o_writes); end
    run_load(5'd5, 5'd3, 32'd4, 3'b010, 16, 32'hCAFE_F00D);
    checks++; if (o_req != 16 || o_done_cyc != 19 || o_err_cyc != 0) begin
      errors++; $display("FAIL timeout_last_ack: req=%0d done=%0d err=%0d expected 16 19 0", o_req, o_done_cyc, o_err_cyc);
    end
    checks++; if (o_wdata !== 32'hCAFE_F00D || o_wreg !== 5'd3) begin
      errors++; $display("FAIL timeout_last_data: got %h reg %0d expected cafef00d reg 3", o_wdata, o_wreg);
    end
  endtask

  task automatic test_dest_zero();
    rf_model[5] = 32'h0000_1000;
    run_load(5'd5, 5'd0, 32'd0, 3'b010, 2, 32'h1234_5678);
    checks++; if (o_done_cyc != 5) begin errors++; $display("FAIL dest0_done: got cycle %0d expected 5", o_done_cyc); end
    checks++; if (o_writes != 0) begin errors++; $display("FAIL dest0_write: got %0d expected 0", o_writes); end
  endtask

  task automatic test_reset_mid();
    int bad;
    rf_model[5] = 32'h0000_2000;
    ld_base_reg = 5'd5; ld_dest_reg = 5'd8; ld_offset = 32'd0; ld_funct3 = 3'b010; ld_valid = 1'b1;
    tick();
    ld_valid = 1'b0;
    tick(); tick();
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL mid_in_wait: mem_req=%b expected 1", mem_req); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
    tick();
    mem_ack = 1'b0;
    checks++; if (mem_req !== 1'b0 || ld_ready !== 1'b1) begin
      errors++; $display("FAIL mid_after_reset: mem_req=%b ready=%b expected 0 1", mem_req, ld_ready);
    end
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (ld_done || rf_reg_write || mem_req) bad++;
      tick();
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL mid_stale: got %0d active cycles expected 0", bad); end
    run_load(5'd5, 5'd8, 32'd4, 3'b010, 1, 32'h0BAD_F00D);
    checks++; if (o_done_cyc != 4 || o_wdata !== 32'h0BAD_F00D || o_addr !== 32'h0000_2004) begin
      errors++; $display("FAIL mid_recover: done=%0d data=%h addr=%h expected 4 0badf00d 00002004", o_done_cyc, o_wdata, o_addr);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf_model[i] = 32'd0;
    test_reset();
    test_lw_basic();
    test_extract();
    test_errors();
    test_timeout();
    test_dest_zero();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
